// File: rtl/pc.sv
// Program counter: a single WIDTH-bit register that loads the upstream
// next-PC value on every rising clock edge. Reset is asynchronous and
// active-high, and it forces the register to RESET_VALUE.
module pc #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] PCInput,
  output logic [WIDTH-1:0] PCOutput
);

  logic [WIDTH-1:0] pc_q;

  // Loads the next PC every cycle. Reset takes priority over the clock.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= PCInput;
    end
  end

  // The output comes straight from the register, with no path from PCInput.
  assign PCOutput = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc. It uses a scoreboard queue of expected PC values.
module tb_pc;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             RST;
  logic [WIDTH-1:0] PCInput;
  logic [WIDTH-1:0] PCOutput;

  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pc #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
    .clk      (clk),
    .RST      (RST),
    .PCInput  (PCInput),
    .PCOutput (PCOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one value at the falling edge and queues the expected PC.
  // After the next rising edge it pops the expected value and compares it.
  task automatic step(input string tag, input logic [WIDTH-1:0] v);
    @(negedge clk);
    PCInput = v;
    exp_q.push_back(RST ? '0 : v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag, PCOutput, exp_q.pop_front());
    end
  endtask

  logic [WIDTH-1:0] held;
  logic [WIDTH-1:0] r;

  initial begin
    RST     = 1'b0;
    PCInput = 8'h00;

    // Async reset: clk is low and no edge occurs.
    #2;
    RST = 1'b1;
    #1;
    check("async_rst", PCOutput, 8'h00);

    // While reset is held, clock edges do not load PCInput.
    step("rst_hold_00", 8'h00);
    step("rst_hold_5a", 8'h5A);
    step("rst_hold_ff", 8'hFF);

    // Releasing reset does not change the PC until the next rising edge.
    @(negedge clk);
    PCInput = 8'h2A;
    #1;
    RST = 1'b0;
    #1;
    check("release_no_change", PCOutput, 8'h00);
    exp_q.push_back(8'h2A);
    @(posedge clk);
    #1;
    check("release_first_load", PCOutput, exp_q.pop_front());

    // Changing PCInput between edges must not reach the output early.
    @(negedge clk);
    PCInput = 8'h13;
    #1;
    check("no_early_1", PCOutput, 8'h2A);
    PCInput = 8'h06;
    #1;
    check("no_early_2", PCOutput, 8'h2A);
    exp_q.push_back(8'h06);
    @(posedge clk);
    #1;
    check("load_06", PCOutput, exp_q.pop_front());

    // Falling edges have no effect.
    PCInput = 8'hC3;
    @(negedge clk);
    #1;
    check("negedge_ignored", PCOutput, 8'h06);

    // Maximum value is loaded verbatim and held until the next edge.
    step("load_ff", 8'hFF);
    PCInput = 8'h00;
    @(negedge clk);
    #1;
    check("hold_ff", PCOutput, 8'hFF);

    // Mid-run async reset while clk is low.
    #1;
    RST = 1'b1;
    #1;
    check("midrun_rst", PCOutput, 8'h00);
    step("midrun_rst_hold", 8'h77);

    // Release the reset, then load a sweep of random values.
    @(negedge clk);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom_range(0, 255));
      step("rand_load", r);
    end
    step("load_01", 8'h01);
    step("load_80", 8'h80);

    // Reset asserted exactly at a rising clock edge wins over the load.
    @(negedge clk);
    PCInput = 8'hAB;
    @(posedge clk);
    RST = 1'b1;
    #1;
    check("rst_at_edge", PCOutput, 8'h00);
    step("rst_at_edge_hold", 8'hCD);

    @(negedge clk);
    RST = 1'b0;
    step("final_load", 8'h3C);
    held = 8'h3C;
    PCInput = 8'h99;
    #3;
    check("final_hold", PCOutput, held);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
